// File: rtl/router_out_fifo.sv
// router_out_fifo
// ----------------------------------------------------------------------------
// Per-destination output buffer of the 1x3 router. Words are stored as
// {header_tag, byte}; the tag is set for the first word of every packet.
// While a packet is drained, a byte counter tracks how many of its bytes
// (payload plus parity) are still to come, and that counter drives pkt_busy.
// soft_reset flushes the buffer exactly like reset. This is used when the
// destination stops reading.
//
// Ports
//   clock       system clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   soft_reset  synchronous active-high flush from the router synchronizer
//   write_enb   write request for data_in (dropped while full)
//   lfd_state   marks data_in as a packet header (stored as the tag bit)
//   data_in     byte to store
//   read_enb    read request from the destination (ignored while empty)
//   data_out    registered read data, valid the cycle after an accepted read
//   vld_out     FIFO non-empty
//   full        FIFO full
//   empty       FIFO empty
//   pkt_busy    a packet is partially read out
//
// The header length field is taken from data bits [7:2], so WIDTH >= 8.
// ----------------------------------------------------------------------------
module router_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             pkt_busy
);

    localparam int CW = 6;

    logic [WIDTH:0]   mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    pkt_cnt_reg, pkt_cnt_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;

    logic             flush;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH:0]   rd_word;

    assign flush = reset | soft_reset;

    // The extra pointer MSB distinguishes full from empty when the
    // address bits are equal.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign vld_out = ~empty;

    // The write and read decisions use the flags from before this edge.
    // A read on a full FIFO therefore does not let a write in during the
    // same cycle.
    assign wr_acc = write_enb & ~full;
    assign rd_acc = read_enb & ~empty;

    assign rd_word = mem[rd_ptr_reg[AW-1:0]];

    // Memory contents are don't-care after a flush, so the array itself has
    // no reset. This allows it to map onto plain RAM.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr_reg[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        data_out_next = data_out_reg;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, 1'b1};
        end

        if (rd_acc) begin
            rd_ptr_next   = rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            data_out_next = rd_word[WIDTH-1:0];
            if (rd_word[WIDTH]) begin
                // A header reloads the count with payload length plus parity.
                pkt_cnt_next = rd_word[7:2] + 6'd1;
            end else if (pkt_cnt_reg != '0) begin
                pkt_cnt_next = pkt_cnt_reg - 6'd1;
            end
        end else if (pkt_cnt_reg == '0) begin
            // Between packets the output bus idles at zero. It clears one
            // cycle after the parity byte has been shown.
            data_out_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pkt_cnt_reg  <= '0;
            data_out_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            data_out_reg <= data_out_next;
        end
    end

    assign data_out = data_out_reg;
    assign pkt_busy = (pkt_cnt_reg != '0);

endmodule

// File: tb/tb_router_out_fifo.sv
// Self-checking bench for router_out_fifo. A queue-based reference model
// runs alongside the DUT and is compared on every falling edge. The directed
// sequences also carry hand-computed literal expectations.
module tb_router_out_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       vld_out, full, empty, pkt_busy;

    int total = 0;
    int bad   = 0;

    router_out_fifo #(.WIDTH(8), .DEPTH(16), .AW(4)) dut (
        .clock      (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: packet-level view kept as a queue of tagged words.
    logic [8:0] q[$];
    logic [5:0] m_cnt  = 6'd0;
    logic [7:0] m_dout = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_rd_ok, m_wr_ok;
    logic [8:0] m_word;

    always @(posedge clk) begin
        if (reset || soft_reset) begin
            q.delete();
            m_cnt   = 6'd0;
            m_dout  = 8'h00;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_rd_ok = read_enb && (q.size() > 0);
            m_wr_ok = write_enb && (q.size() < 16);
            if (m_rd_ok) begin
                m_word = q.pop_front();
                m_dout = m_word[7:0];
                if (m_word[8])
                    m_cnt = m_word[7:2] + 6'd1;
                else if (m_cnt != 0)
                    m_cnt = m_cnt - 6'd1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (m_wr_ok)
                q.push_back({lfd_state, data_in});
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_empty",    empty,    q.size() == 0);
            chk("m_full",     full,     q.size() == 16);
            chk("m_vld_out",  vld_out,  q.size() != 0);
            chk("m_data_out", data_out, m_dout);
            chk("m_pkt_busy", pkt_busy, m_cnt != 0);
        end
    end

    // One clock of stimulus, applied at a falling edge and held through the
    // next rising edge.
    task automatic cyc(input logic w, input logic l, input logic [7:0] d, input logic r);
        write_enb = w;
        lfd_state = l;
        data_in   = d;
        read_enb  = r;
        @(negedge clk);
        write_enb = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        read_enb  = 1'b0;
    endtask

    logic [7:0] t1_data [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
    logic       t1_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] t1_wr   [5] = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h5F};

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset state, then a single packet
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_vld", vld_out, 0);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_busy", pkt_busy, 0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, i == 0, t1_wr[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("t1_dout", data_out, t1_data[i]);
            chk("t1_busy", pkt_busy, t1_busy[i]);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("t1_idle_dout", data_out, 8'h00);

        // 2: fill, overflow attempt, drain
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
        chk("t2_full", full, 1);
        cyc(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("t2_full_after_drop", full, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("t2_dout", data_out, 8'h10 + 8'(i));
        end
        chk("t2_empty", empty, 1);

        // 3: read and write together while full
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 8'h77, 1'b1);
        chk("t3_full_drop", full, 0);
        chk("t3_dout", data_out, 8'h40);
        cyc(1'b1, 1'b0, 8'h77, 1'b0);
        chk("t3_full_again", full, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("t3_dout_order", data_out, (i < 15) ? 8'h41 + 8'(i) : 8'h77);
        end
        chk("t3_empty", empty, 1);

        // 4: read and write together while empty
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h3C, 1'b1);
        chk("t4_dout_zero", data_out, 8'h00);
        chk("t4_vld", vld_out, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t4_dout", data_out, 8'h3C);

        // 5: soft reset mid-packet (header len=10 -> 0x28)
        cyc(1'b1, 1'b1, 8'h28, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 8'h99, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_busy_mid", pkt_busy, 1);
        chk("t5_dout_mid", data_out, 8'h62);
        soft_reset = 1'b1;
        cyc(1'b1, 1'b0, 8'hEE, 1'b1);
        soft_reset = 1'b0;
        chk("t5_empty", empty, 1);
        chk("t5_busy", pkt_busy, 0);
        chk("t5_dout", data_out, 8'h00);
        cyc(1'b1, 1'b1, 8'h05, 1'b0);
        cyc(1'b1, 1'b0, 8'hB1, 1'b0);
        cyc(1'b1, 1'b0, 8'hC2, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_hdr", data_out, 8'h05);
        chk("t5_hdr_busy", pkt_busy, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_pay", data_out, 8'hB1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_par", data_out, 8'hC2);
        chk("t5_par_busy", pkt_busy, 0);

        // 6: wrap-around from a fresh reset
        reset = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b0, 8'h80 + 8'(i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("t6_dout_a", data_out, 8'h80 + 8'(i));
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
            chk("t6_full", full, i == 15);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("t6_dout_b", data_out, 8'hC0 + 8'(i));
        end
        chk("t6_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_out_fifo.md
Name: router_out_fifo

Overview:
- Per-destination output buffer of the 1x3 router. Sits between the router's write/FSM logic and the destination port, which is driven as dout / vld_out / rd_enb by the destination agent.
- Stores one or more packets (header, payload, parity). Tags each header word on write and tracks the remaining byte count of the packet currently being read out.
- Supports a soft reset, asserted by the synchronizer when the destination does not read within its timeout, which flushes the buffer.

Parameters:
- WIDTH, 8, data byte width. Stored word is WIDTH+1 bits; the MSB is the header tag.
- DEPTH, 16, number of entries. Must be a power of 2.
- AW, 4, address width, equal to log2(DEPTH).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous, active-high flush from the router synchronizer.
- write_enb  in  1  write request for data_in.
- lfd_state  in  1  high with write_enb when data_in is a packet header.
- data_in  in  WIDTH  byte to store.
- read_enb  in  1  read request, driven from the destination rd_enb.
- data_out  out  WIDTH  registered read data, wired to destination dout.
- vld_out  out  1  FIFO non-empty.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- pkt_busy  out  1  a packet is partially read out (byte count != 0).

Behaviour:
- Reset and soft_reset (either high at a posedge) have the same effect:
  - wr_ptr, rd_ptr and pkt_cnt go to 0; data_out goes to 0.
  - empty=1, full=0, vld_out=0, pkt_busy=0.
  - Memory contents are don't-care.
  - Takes priority over any write or read in the same cycle, including mid-packet.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]).
  - vld_out = ~empty. empty, full and vld_out are combinational from the pointers.
- Write, accepted when write_enb && !full:
  - mem[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments.
  - Write while full is dropped with no state change.
- Read, accepted when read_enb && !empty:
  - data_out <= mem[rd_ptr][WIDTH-1:0]; rd_ptr increments.
  - Latency: data is valid on data_out the cycle after the read is accepted.
- Simultaneous read and write:
  - Both accepted independently per their own conditions.
  - When full, the write is still rejected that cycle, even though a read frees a slot.
  - When empty, the read is rejected and the write is accepted.
- Packet byte counter pkt_cnt (6 bits):
  - Accepted read of a word with tag=1: pkt_cnt <= word[7:2] + 1 (payload length + parity byte).
  - Accepted read with tag=0 and pkt_cnt != 0: pkt_cnt <= pkt_cnt - 1.
  - Tag=0 read with pkt_cnt == 0 (stray data): pkt_cnt stays 0.
  - pkt_busy = (pkt_cnt != 0), registered via pkt_cnt.
- data_out idle rule:
  - If no read is accepted and pkt_cnt == 0, data_out <= 0.
  - Otherwise data_out holds its value.
  - So data_out returns to 0 one cycle after the parity byte has been presented.
- Wrap-around: pointers wrap naturally at 2*DEPTH. A full fill/drain/fill sequence must preserve order.
- No combinational path from read_enb to data_out.

Test Plan:
1. Reset → empty=1, full=0, vld_out=0, data_out=0, pkt_busy=0. Then write header 0x0D (lfd=1, len=3), payload 0xA1 0xA2 0xA3, parity 0x5F, then assert read_enb for 5 cycles → data_out sequence 0x0D,0xA1,0xA2,0xA3,0x5F, each one cycle after its read. pkt_cnt after the header read = 4; pkt_busy falls after the 0x5F read; data_out=0 the next cycle.
2. Write 16 bytes with no reads → full=1 after the 16th. A 17th write with 0xFF is dropped. Draining 16 reads returns the original 16 bytes in order; empty=1 after the last.
3. Full FIFO, read_enb and write_enb together with 0x77 → read accepted, write rejected, full drops to 0. A repeat write next cycle is accepted and 0x77 appears 16th in read order.
4. Empty FIFO, read_enb and write_enb together with 0x3C → read ignored and data_out stays 0; vld_out=1 next cycle; a following read yields 0x3C.
5. Mid-packet (header len=10, 4 bytes read), assert soft_reset for 1 cycle → next cycle empty=1, pkt_busy=0, data_out=0. A new packet (header 0x05) then reads back correctly from entry 0.
6. Wrap: write 12, read 12, write 16, read 16 → full asserted exactly at the 16th write of the second batch; all data in order; empty=1 at the end.
